// File: rtl/game_pkg.sv
// Shared keypad/display definitions: button FSM states, symbol sizing and
// one-hot helpers used by both the button encoder and the LED display.
package game_pkg;

  localparam int NUM_SYMBOLS = 8;
  localparam int SYM_W       = 3;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_HELD       = 2'd2,
    ST_RELEASE_DB = 2'd3
  } btn_state_t;

  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

  // Index of the highest set bit; only meaningful when is_onehot(v) holds.
  function automatic logic [2:0] onehot_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// SYNC_STAGES-deep, 8-bit flip-flop synchroniser for the raw keypad lines.
// Synchronous active-low reset.
module btn_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] d,
  output logic [7:0] q
);

  logic [SYNC_STAGES-1:0][7:0] stages;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stages <= '0;
    end else begin
      stages[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/button_encoder.sv
// Keypad front-end: synchronise, debounce and encode one-hot buttons into
// 3-bit symbols. Optional led_echo output enabled by defining BUTTON_ECHO_EN.
//
// state         | meaning
// ST_IDLE       | no button seen
// ST_PRESS_DB   | candidate press, waiting for it to stay stable
// ST_HELD       | press accepted (or swallowed), waiting for release
// ST_RELEASE_DB | all buttons up, waiting for the release to stay stable
module button_encoder
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SYMBOLS-1:0] btn,
  input  logic                   en,
  input  logic                   clr,
  output logic [SYM_W-1:0]       code,
  output logic                   code_valid,
  output logic                   multi_err,
`ifdef BUTTON_ECHO_EN
  output logic [NUM_SYMBOLS-1:0] led_echo,
`endif
  output logic                   busy
);

  localparam logic [15:0] DEB = 16'(DEBOUNCE_CYCLES);

  logic [NUM_SYMBOLS-1:0] s;
  logic [NUM_SYMBOLS-1:0] cand;
  logic [15:0]            cnt;
  logic [15:0]            cnt_inc;
  logic                   done;
  btn_state_t             state;
`ifdef BUTTON_ECHO_EN
  logic                   acc;
`endif

  btn_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (btn),
    .q    (s)
  );

  // Completion is judged on the incremented count so the cycle that first
  // sees the new value counts as stable cycle 1.
  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  assign done    = (cnt_inc == DEB);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      cand       <= '0;
      code       <= '0;
      code_valid <= 1'b0;
      multi_err  <= 1'b0;
      busy       <= 1'b0;
`ifdef BUTTON_ECHO_EN
      led_echo   <= '0;
      acc        <= 1'b0;
`endif
    end else begin
      code_valid <= 1'b0;
      multi_err  <= 1'b0;
      if (clr) begin
        state <= ST_RELEASE_DB;
        cnt   <= 16'd1;
        cand  <= '0;
        busy  <= 1'b1;
`ifdef BUTTON_ECHO_EN
        led_echo <= '0;
        acc      <= 1'b0;
`endif
      end else begin
        case (state)
          ST_IDLE: begin
            if (s != '0) begin
              cand  <= s;
              cnt   <= 16'd1;
              state <= ST_PRESS_DB;
              busy  <= 1'b1;
            end
          end
          ST_PRESS_DB: begin
            if (s != cand) begin
              if (s == '0) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end else begin
                cand <= s;
                cnt  <= 16'd1;
              end
            end else begin
              cnt <= cnt_inc;
              if (done) begin
                state <= ST_HELD;
                // With en low the press is swallowed without any strobe.
                if (en) begin
                  if (is_onehot(cand)) begin
                    code       <= onehot_index(cand);
                    code_valid <= 1'b1;
`ifdef BUTTON_ECHO_EN
                    led_echo   <= cand;
                    acc        <= 1'b1;
`endif
                  end else begin
                    multi_err <= 1'b1;
                  end
                end
              end
            end
          end
          ST_HELD: begin
            if (s == '0) begin
              cnt   <= 16'd1;
              state <= ST_RELEASE_DB;
`ifdef BUTTON_ECHO_EN
              led_echo <= '0;
`endif
            end
          end
          ST_RELEASE_DB: begin
            if (s != '0) begin
              state <= ST_HELD;
`ifdef BUTTON_ECHO_EN
              led_echo <= acc ? cand : '0;
`endif
            end else begin
              cnt <= cnt_inc;
              if (done) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
`ifdef BUTTON_ECHO_EN
                acc   <= 1'b0;
`endif
              end
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_button_encoder.sv
// Directed self-checking bench for button_encoder (DEBOUNCE_CYCLES=4,
// SYNC_STAGES=2); led_echo checks are included when BUTTON_ECHO_EN is defined.
module tb_button_encoder;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] btn;
  logic       en;
  logic       clr;
  logic [2:0] code;
  logic       code_valid;
  logic       multi_err;
  logic       busy;
`ifdef BUTTON_ECHO_EN
  logic [7:0] led_echo;
`endif

  int total = 0;
  int bad   = 0;
  int cv_cnt;
  int me_cnt;

  button_encoder #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn       (btn),
    .en        (en),
    .clr       (clr),
    .code      (code),
    .code_valid(code_valid),
    .multi_err (multi_err),
`ifdef BUTTON_ECHO_EN
    .led_echo  (led_echo),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps n cycles, counting strobes seen after each edge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (code_valid === 1'b1) cv_cnt++;
      if (multi_err === 1'b1) me_cnt++;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; btn = 8'h00; en = 1'b1; clr = 1'b0;
    step(); step(); step();
    rst_n = 1'b1;
    step();
    chk("rst_code", 16'(code), 16'd0);
    chk("rst_cv", 16'(code_valid), 16'd0);
    chk("rst_me", 16'(multi_err), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
`ifdef BUTTON_ECHO_EN
    chk("rst_echo", 16'(led_echo), 16'd0);
`endif

    // Clean press of button 5
    btn = 8'h20;
    run(5);
    chk("clean_cv_early", 16'(code_valid), 16'd0);
    step();
    chk("clean_cv", 16'(code_valid), 16'd1);
    chk("clean_code", 16'(code), 16'd5);
    chk("clean_busy", 16'(busy), 16'd1);
    step();
    chk("clean_cv_one", 16'(code_valid), 16'd0);
    run(5);
    btn = 8'h00;
    run(5);
    chk("rel_busy_hold", 16'(busy), 16'd1);
    step();
    chk("rel_busy_drop", 16'(busy), 16'd0);
    chk("rel_code_hold", 16'(code), 16'd5);

    // Bouncing press of button 2
    cv_cnt = 0; me_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      btn = (i % 2 == 0) ? 8'h04 : 8'h00;
      run(1);
    end
    btn = 8'h04;
    run(5);
    chk("bounce_early", 16'(cv_cnt), 16'd0);
    step();
    chk("bounce_cv", 16'(code_valid), 16'd1);
    chk("bounce_code", 16'(code), 16'd2);
    run(10);
    chk("bounce_once", 16'(cv_cnt), 16'd0);
    btn = 8'h00;
    run(8);
    chk("bounce_idle", 16'(busy), 16'd0);

    // Two buttons together, then a clean button 1
    cv_cnt = 0; me_cnt = 0;
    btn = 8'h81;
    run(5);
    chk("multi_early", 16'(multi_err), 16'd0);
    step();
    chk("multi_me", 16'(multi_err), 16'd1);
    chk("multi_cv", 16'(code_valid), 16'd0);
    chk("multi_code_hold", 16'(code), 16'd2);
    run(4);
    chk("multi_me_once", 16'(me_cnt), 16'd0);
    chk("multi_no_cv", 16'(cv_cnt), 16'd0);
    btn = 8'h00;
    run(8);
    btn = 8'h02;
    run(6);
    chk("after_multi_cv", 16'(code_valid), 16'd1);
    chk("after_multi_code", 16'(code), 16'd1);
    btn = 8'h00;
    run(8);

    // Gated press: en low across completion, raised while held
    cv_cnt = 0; me_cnt = 0;
    en = 1'b0;
    btn = 8'h01;
    run(6);
    chk("gated_cv", 16'(cv_cnt), 16'd0);
    chk("gated_state", 16'(dut.state), 16'(ST_HELD));
    en = 1'b1;
    run(5);
    chk("gated_late_en", 16'(cv_cnt + me_cnt), 16'd0);
    btn = 8'h00;
    run(8);
    chk("gated_idle", 16'(busy), 16'd0);

    // clr on the completion cycle of a button 3 press
    cv_cnt = 0; me_cnt = 0;
    btn = 8'h08;
    run(5);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_cv", 16'(code_valid), 16'd0);
    chk("clr_state", 16'(dut.state), 16'(ST_RELEASE_DB));
    chk("clr_busy", 16'(busy), 16'd1);
    run(6);
    chk("clr_no_symbol", 16'(cv_cnt + me_cnt), 16'd0);
    chk("clr_code_hold", 16'(code), 16'd1);
    btn = 8'h00;
    run(8);

    // Reset in the middle of press debounce
    btn = 8'h40;
    run(4);
    chk("mid_state", 16'(dut.state), 16'(ST_PRESS_DB));
    rst_n = 1'b0;
    step();
    btn = 8'h00;
    chk("mrst_state", 16'(dut.state), 16'(ST_IDLE));
    chk("mrst_code", 16'(code), 16'd0);
    chk("mrst_busy", 16'(busy), 16'd0);
    chk("mrst_strobes", 16'({code_valid, multi_err}), 16'd0);
    rst_n = 1'b1;
    cv_cnt = 0; me_cnt = 0;
    run(8);
    chk("mrst_dropped", 16'(cv_cnt + me_cnt), 16'd0);

`ifdef BUTTON_ECHO_EN
    // Echo of the accepted key while held
    btn = 8'h10;
    run(5);
    chk("echo_early", 16'(led_echo), 16'd0);
    step();
    chk("echo_cv", 16'(code_valid), 16'd1);
    chk("echo_on", 16'(led_echo), 16'h10);
    run(4);
    chk("echo_hold", 16'(led_echo), 16'h10);
    btn = 8'h00;
    run(2);
    chk("echo_still", 16'(led_echo), 16'h10);
    step();
    chk("echo_off", 16'(led_echo), 16'd0);
    run(6);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
